muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative RV64M multiply/divide unit with its own sequencing FSM, sitting in the execute stage beside the single-cycle ALU. It accepts one operation at a time through a valid/ready handshake on the decoder's `mulOp` encoding. It computes radix-2 shift-add products and restoring-division quotients/remainders over a fixed number of cycles. The result is returned as a one-cycle `valid_o` pulse, and the pipeline stalls on `busy_o`.

## Interface
- `XLEN`, 64, operand/result width; only 64 is supported.
- `clk  in  1  clock, rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `valid_i  in  1  operation request`
- `ready_o  out  1  unit idle, can accept this cycle`
- `op_i  in  4  {isW, funct3}; funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu`
- `a_i, b_i  in  64 each  rs1/rs2 operand values`
- `flush_i  in  1  pipeline flush, aborts current operation`
- `valid_o  out  1  result valid, single-cycle pulse`
- `result_o  out  64  result; held until next accepted op`
- `busy_o  out  1  accepted op not yet completed (stall request)`

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Accept: `valid_i && ready_o && !flush_i` at an edge. On accept, the unit latches op, operand magnitudes and sign flags, clears the iteration counter, and goes to CALC. Special-case division goes to FIX instead.
- W ops (isW=1):
  - Valid funct3: 000, 100, 101, 110, 111.
  - Operands are the low 32 bits, sign- or zero-extended per signedness.
  - The 32-bit result is sign-extended to 64 bits, including divuw/remuw.
  - isW with funct3 001–011 is treated as mul (W).
- Signedness:
  - mul, mulh, div, rem: both operands signed.
  - mulhsu: a signed, b unsigned.
  - mulhu, divu, remu: both unsigned.
- Multiply: 128-bit product of magnitudes, one bit of b per CALC cycle. FIX negates the product when the sign flags differ. mul selects [63:0]; mulh/mulhsu/mulhu select [127:64].
- Divide: restoring, one quotient bit per CALC cycle, on magnitudes. FIX applies the signs: quotient negated when sa≠sb, remainder takes the sign of a.
- Special cases (bypass CALC; handled in FIX):
  - Divide by zero: quotient = all ones; remainder = a (W: sign-extended low 32 bits of a).
  - Signed overflow (a = most negative value, b = −1, width per isW): quotient = a; remainder = 0.
- Iteration count N: 64 for 64-bit ops, 32 for W ops. CALC exits to FIX when the counter reaches N−1.
- DONE asserts `valid_o` for exactly one cycle, then returns to IDLE.
- Flush has priority over everything:
  - `flush_i` in CALC/FIX/DONE → IDLE at the next edge; no `valid_o` is produced.
  - `valid_o` is gated combinationally by `!flush_i`.
  - `result_o` is left unchanged.

## Timing
- Reset values: state IDLE, `ready_o`=1, `busy_o`=0, `valid_o`=0, `result_o`=0, counter 0.
- Reset asserted mid-operation: immediate return to IDLE; the operation is lost.
- `ready_o` = (state==IDLE). `busy_o` = (state≠IDLE).
- Latency (acceptance edge E0 → cycle in which `valid_o`=1):
  - 64-bit ops: cycle after edge E0+N+1, i.e. N+2 cycles.
  - W ops: 34 cycles.
  - Special-case division: 2 cycles.
- `result_o` is registered in FIX and is stable from the `valid_o` cycle until the next acceptance.
- Back-to-back: `ready_o` is high the cycle after `valid_o`. The earliest next acceptance is at the edge ending that cycle.
- `valid_i` while busy is ignored; the requester holds it.
- `valid_i && flush_i` together: not accepted.

## Test plan
- Multiply and latency:
  - mul a=0x10000, b=0x10000 → `result_o`=0x1_0000_0000, `valid_o` exactly 66 cycles after acceptance, one cycle wide.
  - mulh a=b=0xFFFF_FFFF_FFFF_FFFF → 0.
  - mulhu same operands → 0xFFFF_FFFF_FFFF_FFFE.
  - mulhsu a=−1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- Division special cases:
  - div a=7, b=0 → 0xFFFF_FFFF_FFFF_FFFF after 2 cycles.
  - rem a=7, b=0 → 7.
  - div a=0x8000_0000_0000_0000, b=−1 → 0x8000_0000_0000_0000; rem → 0.
- Signed division: div a=−7, b=2 → −3 (0xFFFF_FFFF_FFFF_FFFD); rem → −1.
- W ops, each 34-cycle latency:
  - divuw a=0xFFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF.
  - mulw a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE.
  - remw a=0xFFFF_FFF9, b=2 → −1.
- Flush and reset:
  - Flush 10 cycles into a div → no `valid_o`; `ready_o`=1 the next cycle.
  - An immediately following mul 3×5 → 15 after 66 cycles.
  - Reset low mid-CALC → `valid_o`=0 and `ready_o`=1 asynchronously.
- Back-to-back and handshake:
  - Two muls accepted on consecutive `ready_o` windows → two `valid_o` pulses 67 cycles apart.
  - `valid_i` held while busy → no second acceptance.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with signs and special cases applied in FIX.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Handshake: an op is accepted at a rising edge where valid_i && ready_o && !flush_i;
  // the requester holds valid_i until then, and the result arrives as a one-cycle
  // valid_o pulse with result_o held until the next acceptance.
  state_t      state;
  logic        is_w, neg_q, neg_r, sp_zero, sp_ovf;
  logic [2:0]  f3;
  logic [5:0]  cnt;
  logic [63:0] hi, lo, opnd;

  logic [2:0]  in_f3;
  logic        in_div, sgn_a, sgn_b, sa, sb, b_zero, ovf;
  logic [63:0] ext_a, ext_b, mag_a, mag_b, sext_a;

  always_comb begin
    in_f3  = (op_i[3] && !op_i[2]) ? 3'b000 : op_i[2:0];
    in_div = in_f3[2];
    sgn_a  = in_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    sgn_b  = in_f3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    ext_a  = op_i[3] ? {{32{sgn_a & a_i[31]}}, a_i[31:0]} : a_i;
    ext_b  = op_i[3] ? {{32{sgn_b & b_i[31]}}, b_i[31:0]} : b_i;
    sa     = sgn_a & ext_a[63];
    sb     = sgn_b & ext_b[63];
    mag_a  = sa ? -ext_a : ext_a;
    mag_b  = sb ? -ext_b : ext_b;
    sext_a = op_i[3] ? {{32{a_i[31]}}, a_i[31:0]} : a_i;
    b_zero = (ext_b == 64'd0);
    ovf    = in_div && !in_f3[0] &&
             (op_i[3] ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == 32'hFFFF_FFFF)
                      : (a_i == 64'h8000_0000_0000_0000 && b_i == 64'hFFFF_FFFF_FFFF_FFFF));
  end

  // One iteration: multiply adds opnd when the current b bit is set and shifts
  // {carry,hi,lo} right; divide shifts {hi,lo} left and subtracts when it fits.
  logic [64:0] sum65, sh65, diff65;
  logic [63:0] step_hi, step_lo;

  always_comb begin
    sum65  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 65'd0);
    sh65   = {hi, lo[63]};
    diff65 = sh65 - {1'b0, opnd};
    if (f3[2]) begin
      step_hi = diff65[64] ? sh65[63:0] : diff65[63:0];
      step_lo = {lo[62:0], ~diff65[64]};
    end else begin
      step_hi = sum65[64:1];
      step_lo = {sum65[0], lo[63:1]};
    end
  end

  logic [127:0] prod, prod_s;
  logic [63:0]  quo, rem, dsel, fix_res;

  always_comb begin
    prod   = is_w ? {64'd0, hi[31:0], lo[63:32]} : {hi, lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo : lo;
    rem    = neg_r ? -hi : hi;
    if (sp_zero) begin
      quo = 64'hFFFF_FFFF_FFFF_FFFF;
      rem = lo;
    end else if (sp_ovf) begin
      quo = lo;
      rem = 64'd0;
    end
    dsel = f3[1] ? rem : quo;
    if (f3[2])
      fix_res = is_w ? {{32{dsel[31]}}, dsel[31:0]} : dsel;
    else if (f3 == 3'b000)
      fix_res = is_w ? {{32{prod_s[31]}}, prod_s[31:0]} : prod_s[63:0];
    else
      fix_res = prod_s[127:64];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      result_o <= '0;
      hi       <= 64'd0;
      lo       <= 64'd0;
      opnd     <= 64'd0;
      is_w     <= 1'b0;
      f3       <= 3'b000;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sp_zero  <= 1'b0;
      sp_ovf   <= 1'b0;
    end else if (flush_i && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (valid_i && !flush_i) begin
          is_w    <= op_i[3];
          f3      <= in_f3;
          cnt     <= 6'd0;
          hi      <= 64'd0;
          neg_q   <= sa ^ sb;
          neg_r   <= sa;
          sp_zero <= in_div & b_zero;
          sp_ovf  <= ovf;
          if (in_div) begin
            opnd <= mag_b;
            if (b_zero || ovf) begin
              lo    <= sext_a;
              state <= FIX;
            end else begin
              // W dividends start in the upper half so 32 shifts consume them.
              lo    <= op_i[3] ? {mag_a[31:0], 32'd0} : mag_a;
              state <= CALC;
            end
          end else begin
            opnd  <= mag_a;
            lo    <= mag_b;
            state <= CALC;
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 6'd1;
          if (cnt == (is_w ? 6'd31 : 6'd63)) state <= FIX;
        end
        FIX: begin
          result_o <= fix_res;
          state    <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o   = (state == IDLE);
  assign busy_o    = (state != IDLE);
  assign valid_o   = (state == DONE) && !flush_i;
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random ops against an arithmetic model of
// RV64M results and latencies, plus flush, reset and handshake scenarios.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [63:0] a_i = 64'd0;
  logic [63:0] b_i = 64'd0;
  logic        ready_o, valid_o, busy_o;
  logic [63:0] result_o;
  logic [1:0]  dbg_state;

  muldiv_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .valid_o(valid_o), .result_o(result_o), .busy_o(busy_o),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  bit          inflight = 1'b0;
  logic [63:0] last_result = 64'd0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          vcyc[$];

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [2:0] norm_f3(input logic [3:0] op);
    if (op[3] && op[2:0] inside {3'd1, 3'd2, 3'd3}) return 3'd0;
    return op[2:0];
  endfunction

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [2:0]   f;
    logic [127:0] p;
    logic [31:0]  a32, b32, t32;
    longint       sa, sb;
    int           sa32, sb32;
    logic         ovf64, ovf32;
    f = norm_f3(op);
    a32 = a[31:0]; b32 = b[31:0];
    sa = a; sb = b; sa32 = a32; sb32 = b32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    p = 128'd0;
    if (!op[3]) begin
      case (f)
        3'd0: return a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
        3'd4: if (b == 0) return '1; else if (ovf64) return a; else return sa / sb;
        3'd5: if (b == 0) return '1; else return a / b;
        3'd6: if (b == 0) return a; else if (ovf64) return 64'd0; else return sa % sb;
        default: if (b == 0) return a; else return a % b;
      endcase
    end else begin
      case (f)
        3'd4: if (b32 == 0) return '1; else if (ovf32) return sx(a32); else return sx(32'(sa32 / sb32));
        3'd5: if (b32 == 0) return '1; else return sx(a32 / b32);
        3'd6: if (b32 == 0) return sx(a32); else if (ovf32) return 64'd0; else return sx(32'(sa32 % sb32));
        3'd7: if (b32 == 0) return sx(a32); else return sx(a32 % b32);
        default: begin t32 = a32 * b32; return sx(t32); end
      endcase
    end
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [2:0] f;
    logic       special;
    f = norm_f3(op);
    if (op[3])
      special = (b[31:0] == 0) || (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else
      special = (b == 0) || (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (f[2] && special) return 2;
    return op[3] ? 34 : 66;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 40));
      4: return {$urandom, $urandom};
      5: return {$urandom, 32'h8000_0000};
      default: return {32'hFFFF_FFFF, $urandom};
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input bit expect_res, input bit hold);
    int guard;
    guard = 0;
    while (!ready_o && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL issue_timeout: ready_o stuck at %b expected 1", ready_o);
      return;
    end
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    inflight = 1'b1;
    if (expect_res) begin
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_lat(op, a, b));
      acc_q.push_back(cyc);
    end
    if (hold) begin
      guard = 0;
      while (!valid_o && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || inflight) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || inflight) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_q.delete();
      inflight = 1'b0;
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    logic [63:0] e;
    int          l, ac;
    forever begin
      @(negedge clk);
      if (reset) begin
        check_bit("busy", busy_o, inflight);
        check_bit("ready", ready_o, !inflight);
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_valid: got valid_o=1 result %h expected no pulse", result_o);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            ac = acc_q.pop_front();
            check64("result", result_o, e);
            check_int("latency", cyc - ac + 1, l);
            vcyc.push_back(cyc);
            last_result = e;
            inflight = 1'b0;
          end
        end else if (!inflight) begin
          check64("result_hold", result_o, last_result);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d results outstanding", exp_q.size());
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [3:0]  d_op[14];
  logic [63:0] d_a[14];
  logic [63:0] d_b[14];

  initial begin
    int n0;
    d_op = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0100, 4'b0110, 4'b0100,
             4'b0110, 4'b0100, 4'b0110, 4'b1101, 4'b1000, 4'b1110, 4'b0101};
    d_a  = '{64'h10000, '1, '1, '1, 64'd7, 64'd7, 64'h8000_0000_0000_0000,
             64'h8000_0000_0000_0000, -64'sd7, -64'sd7, 64'hFFFF_FFFF, 64'h7FFF_FFFF,
             64'hFFFF_FFF9, 64'd1000};
    d_b  = '{64'h10000, '1, '1, 64'd2, 64'd0, 64'd0, '1, '1, 64'd2, 64'd2,
             64'd1, 64'd2, 64'd2, 64'd7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_ready", ready_o, 1'b1);
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_valid", valid_o, 1'b0);
    check64("rst_result", result_o, 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-computed values
    check64("pin_mul", model(4'b0000, 64'h10000, 64'h10000), 64'h1_0000_0000);
    check64("pin_mulh", model(4'b0001, '1, '1), 64'd0);
    check64("pin_mulhu", model(4'b0011, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
    check64("pin_mulhsu", model(4'b0010, '1, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check64("pin_div0", model(4'b0100, 64'd7, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    check64("pin_rem0", model(4'b0110, 64'd7, 64'd0), 64'd7);
    check64("pin_divovf", model(4'b0100, 64'h8000_0000_0000_0000, '1), 64'h8000_0000_0000_0000);
    check64("pin_div_neg", model(4'b0100, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check64("pin_rem_neg", model(4'b0110, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check64("pin_divuw", model(4'b1101, 64'hFFFF_FFFF, 64'd1), 64'hFFFF_FFFF_FFFF_FFFF);
    check64("pin_mulw", model(4'b1000, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    check64("pin_remw", model(4'b1110, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check_int("pin_lat_mul", exp_lat(4'b0000, 64'd3, 64'd5), 66);
    check_int("pin_lat_w", exp_lat(4'b1110, 64'd9, 64'd2), 34);
    check_int("pin_lat_div0", exp_lat(4'b0100, 64'd7, 64'd0), 2);

    // Directed vectors through the DUT
    for (int i = 0; i < 14; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, 1'b0);
    drain();

    // Back-to-back muls: pulses N+3 cycles apart
    n0 = vcyc.size();
    issue(4'b0000, 64'd11, 64'd13, 1'b1, 1'b0);
    issue(4'b0000, 64'd17, 64'd19, 1'b1, 1'b0);
    drain();
    if (vcyc.size() >= n0 + 2) check_int("b2b_gap", vcyc[n0 + 1] - vcyc[n0], 67);
    else begin
      checks++; errors++;
      $display("FAIL b2b_pulses: got %0d pulses expected 2", vcyc.size() - n0);
    end

    // Flush 10 cycles into a divide, then an immediate mul
    issue(4'b0100, 64'd1000, 64'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    inflight = 1'b0;
    check_bit("flush_ready", ready_o, 1'b1);
    issue(4'b0000, 64'd3, 64'd5, 1'b1, 1'b0);
    drain();

    // valid_i together with flush_i is not accepted
    op_i = 4'b0000; a_i = 64'd2; b_i = 64'd2;
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check_bit("vflush_ready", ready_o, 1'b1);
    repeat (3) begin @(posedge clk); #1; end

    // valid_i held across the whole operation: single acceptance
    issue(4'b0101, {$urandom, $urandom}, 64'd3, 1'b1, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check_bit("held_idle", ready_o, 1'b1);
    drain();

    // Asynchronous reset mid-CALC
    issue(4'b0000, 64'd7, 64'd9, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_bit("arst_valid", valid_o, 1'b0);
    check_bit("arst_ready", ready_o, 1'b1);
    check_bit("arst_busy", busy_o, 1'b0);
    check64("arst_result", result_o, 64'd0);
    inflight = 1'b0;
    last_result = 64'd0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    // Random operations
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'b1, 1'b0);
    end
    drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
